// File: rtl/seg_digit_sequencer.sv
// Binary-to-BCD (sequential double dabble) then one seven-segment digit per cycle, units first.
// start accepted in IDLE only; done pulses 17..21 cycles after acceptance, 22-cycle issue interval.
module seg_digit_sequencer #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] product,
    output logic [6:0]  seg_code,
    output logic [2:0]  seg_mux_sel,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_EMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_shift, w_shift_nxt;
    logic [19:0] r_bcd, w_bcd_nxt, w_bcd_adj;
    logic [3:0]  r_iter, w_iter_nxt;
    logic [6:0]  r_seg, w_seg_nxt;
    logic [2:0]  r_sel, w_sel_nxt;
    logic        r_done, w_done_nxt;
    logic        r_busy, w_busy_nxt;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b0000001;
            4'd1:    f_seg = 7'b1001111;
            4'd2:    f_seg = 7'b0010010;
            4'd3:    f_seg = 7'b0000110;
            4'd4:    f_seg = 7'b1001100;
            4'd5:    f_seg = 7'b0100100;
            4'd6:    f_seg = 7'b0100000;
            4'd7:    f_seg = 7'b0001111;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0000100;
            default: f_seg = SEG_BLANK;
        endcase
    endfunction

    // A digit above the units is a leading zero when it and every digit above it are zero.
    function automatic logic [6:0] f_digit_code(input logic [19:0] bcd, input logic [2:0] k);
        logic [19:0] upper;
        upper = bcd >> {k, 2'b00};
        if (BLANK_LZ && (k != 3'd0) && (upper == 20'd0))
            f_digit_code = SEG_BLANK;
        else
            f_digit_code = f_seg(upper[3:0]);
    endfunction

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bcd_nxt   = r_bcd;
        w_iter_nxt  = r_iter;
        w_seg_nxt   = r_seg;
        w_sel_nxt   = r_sel;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shift_nxt = product;
                    w_bcd_nxt   = 20'd0;
                    w_iter_nxt  = 4'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                w_bcd_nxt   = {w_bcd_adj[18:0], r_shift[15]};
                w_shift_nxt = {r_shift[14:0], 1'b0};
                w_iter_nxt  = r_iter + 4'd1;
                // Units digit is registered straight from the final shift so done rises right after CONV.
                if (r_iter == 4'd15) begin
                    w_state_nxt = S_EMIT;
                    w_done_nxt  = 1'b1;
                    w_sel_nxt   = 3'd0;
                    w_seg_nxt   = f_digit_code(w_bcd_nxt, 3'd0);
                end
            end
            S_EMIT: begin
                if (r_sel == 3'd4) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_done_nxt = 1'b1;
                    w_sel_nxt  = r_sel + 3'd1;
                    w_seg_nxt  = f_digit_code(r_bcd, r_sel + 3'd1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= 16'd0;
            r_bcd   <= 20'd0;
            r_iter  <= 4'd0;
            r_seg   <= SEG_BLANK;
            r_sel   <= 3'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bcd   <= w_bcd_nxt;
            r_iter  <= w_iter_nxt;
            r_seg   <= w_seg_nxt;
            r_sel   <= w_sel_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign seg_code    = r_seg;
    assign seg_mux_sel = r_sel;
    assign done        = r_done;
    assign busy        = r_busy;

endmodule

// File: tb/tb_seg_digit_sequencer.sv
// Bench for seg_digit_sequencer: both blanking variants side by side against a decimal-arithmetic model.
module tb_seg_digit_sequencer;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] product;
    logic [6:0]  seg1, seg0;
    logic [2:0]  sel1, sel0;
    logic        done1, done0, busy1, busy0;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seg_digit_sequencer #(.BLANK_LZ(1'b1)) u_dut_blank (
        .clk(clk), .rst(rst), .start(start), .product(product),
        .seg_code(seg1), .seg_mux_sel(sel1), .done(done1), .busy(busy1)
    );

    seg_digit_sequencer #(.BLANK_LZ(1'b0)) u_dut_noblank (
        .clk(clk), .rst(rst), .start(start), .product(product),
        .seg_code(seg0), .seg_mux_sel(sel0), .done(done0), .busy(busy0)
    );

    function automatic logic [6:0] f_pat(input int d);
        case (d)
            0: f_pat = P0;  1: f_pat = P1;  2: f_pat = P2;  3: f_pat = P3;
            4: f_pat = P4;  5: f_pat = P5;  6: f_pat = P6;  7: f_pat = P7;
            8: f_pat = P8;  9: f_pat = P9;
            default: f_pat = PB;
        endcase
    endfunction

    // Index k holds the code for decimal place k; a place is blank when the value is below 10^k.
    function automatic logic [4:0][6:0] f_codes(input int v, input bit blank);
        int pw;
        pw = 1;
        for (int k = 0; k < 5; k++) begin
            if (blank && k > 0 && v < pw)
                f_codes[k] = PB;
            else
                f_codes[k] = f_pat((v / pw) % 10);
            pw = pw * 10;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase counts cycles since acceptance; digits appear in phases 17..21.
    int              m_phase = 0;
    logic [4:0][6:0] m_c1, m_c0;
    logic [6:0]      m_seg1, m_seg0;
    logic [2:0]      m_sel;
    logic            m_done, m_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_seg1  <= PB;
            m_seg0  <= PB;
            m_sel   <= 3'd0;
            m_done  <= 1'b0;
            m_busy  <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_busy  <= 1'b1;
                m_c1    <= f_codes(int'(product), 1'b1);
                m_c0    <= f_codes(int'(product), 1'b0);
            end
        end else begin
            if (m_phase + 1 >= 17 && m_phase + 1 <= 21) begin
                m_done <= 1'b1;
                m_sel  <= 3'(m_phase + 1 - 17);
                m_seg1 <= m_c1[m_phase + 1 - 17];
                m_seg0 <= m_c0[m_phase + 1 - 17];
            end else begin
                m_done <= 1'b0;
            end
            if (m_phase + 1 == 22) begin
                m_phase <= 0;
                m_busy  <= 1'b0;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_done_b", done1, m_done);
            chk("model_busy_b", busy1, m_busy);
            chk("model_sel_b",  sel1,  m_sel);
            chk("model_seg_b",  seg1,  m_seg1);
            chk("model_done_n", done0, m_done);
            chk("model_busy_n", busy0, m_busy);
            chk("model_sel_n",  sel0,  m_sel);
            chk("model_seg_n",  seg0,  m_seg0);
        end
    end

    // Starts a conversion now (we sit at a negedge) and ends at the negedge of cycle 22.
    // e1/e0 are packed sel4..sel0 (sel0 in the low bits) for the blanking / non-blanking instances.
    task automatic run_conv(input logic [15:0] v, input logic [4:0][6:0] e1,
                            input logic [4:0][6:0] e0, input int inj_cyc, input logic [15:0] inj_v);
        logic [4:0][6:0] g1, g0;
        int ndone, first;
        g1 = '1;
        g0 = '1;
        ndone = 0;
        first = -1;
        start = 1'b1;
        product = v;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            start = (c == inj_cyc);
            if (c == inj_cyc) product = inj_v;
            if (c == 1) chk("busy_rise", busy1, 1);
            if (done1) begin
                ndone++;
                if (first < 0) first = c;
                if (sel1 <= 3'd4) g1[sel1] = seg1;
                if (sel0 <= 3'd4) g0[sel0] = seg0;
            end
        end
        chk("done_count", ndone, 5);
        chk("first_done_cycle", first, 17);
        chk("busy_fall_c22", busy1, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("digit_b_sel%0d_v%0d", k, v), g1[k], e1[k]);
            chk($sformatf("digit_n_sel%0d_v%0d", k, v), g0[k], e0[k]);
        end
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        start = 1'b0;
        product = 16'd0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_seg", seg1, PB);
        chk("rst_sel", sel1, 0);
        chk("rst_done", done1, 0);
        chk("rst_busy", busy1, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_conv(16'd65025, {P6, P5, P0, P2, P5}, {P6, P5, P0, P2, P5}, 0, 16'd0);
        run_conv(16'd1005,  {PB, P1, P0, P0, P5}, {P0, P1, P0, P0, P5}, 0, 16'd0);
        run_conv(16'd0,     {PB, PB, PB, PB, P0}, {P0, P0, P0, P0, P0}, 0, 16'd0);
        run_conv(16'd87,    {PB, PB, PB, P8, P7}, {P0, P0, P0, P8, P7}, 0, 16'd0);
        run_conv(16'd10000, {P1, P0, P0, P0, P0}, {P1, P0, P0, P0, P0}, 0, 16'd0);

        // Reset in CONV cycle 10.
        start = 1'b1;
        product = 16'd54321;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_seg", seg1, PB);
        chk("midrst_sel", sel1, 0);
        chk("midrst_seg_n", seg0, PB);
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done1 || done0) nd++;
        end
        chk("midrst_no_done", nd, 0);

        run_conv(16'd4321,  {PB, P4, P3, P2, P1}, {P0, P4, P3, P2, P1}, 0, 16'd0);
        run_conv(16'd65535, {P6, P5, P5, P3, P5}, {P6, P5, P5, P3, P5}, 0, 16'd0);
        run_conv(16'd1234,  {PB, P1, P2, P3, P4}, {P0, P1, P2, P3, P4}, 5, 16'd9999);
        run_conv(16'd90,    {PB, PB, PB, P9, P0}, {P0, P0, P0, P9, P0}, 0, 16'd0);

        // Reset and start together: reset wins.
        rst = 1'b1;
        start = 1'b1;
        product = 16'd123;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy1, 0);
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done1 || busy1) nd++;
        end
        chk("rst_start_dropped", nd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
